// File: rtl/calculator_pkg.sv
// calculator_pkg: shared calculator widths plus result packing types.
// Provides DATA_W, MEM_WORD_SIZE, RESULT_SLOTS, slot_mask_t and pack_state_t.
package calculator_pkg;
    localparam int DATA_W        = 32;
    localparam int MEM_WORD_SIZE = 64;
    localparam int RESULT_SLOTS  = MEM_WORD_SIZE / DATA_W;

    typedef logic [RESULT_SLOTS-1:0] slot_mask_t;

    typedef enum logic [1:0] {EMPTY, FILLING, FLUSH_WAIT} pack_state_t;
endpackage

// File: rtl/result_pack_buffer_if.sv
// result_pack_buffer_if: ALU result input stream and packed-word output stream.
// Signals: result/in_valid/in_ready/flush (input side),
//          buffer/slot_mask/out_valid/out_ready (output side), fill_cnt (status).
// Modports: slave = packing block, master = producer/consumer environment.
interface result_pack_buffer_if #(
    parameter int DATA_W = calculator_pkg::DATA_W,
    parameter int OUT_W  = calculator_pkg::MEM_WORD_SIZE,
    localparam int SLOTS = OUT_W / DATA_W,
    localparam int CW    = $clog2(SLOTS)
);
    logic [DATA_W-1:0] result;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [OUT_W-1:0]  buffer;
    logic [SLOTS-1:0]  slot_mask;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     fill_cnt;

    modport slave (
        input  result, in_valid, flush, out_ready,
        output in_ready, buffer, slot_mask, out_valid, fill_cnt
    );

    modport master (
        output result, in_valid, flush, out_ready,
        input  in_ready, buffer, slot_mask, out_valid, fill_cnt
    );
endinterface

// File: rtl/result_pack_ctrl.sv
// result_pack_ctrl: fill counter, packing FSM, pending flush and in_ready.
// Ports: clk_i/rst_i (async active-high), in_valid, flush, out_valid, out_ready in;
//        in_ready, accept (result taken), emit (word moves to output), fill_cnt out.
module result_pack_ctrl
    import calculator_pkg::*;
#(
    parameter int SLOTS = RESULT_SLOTS,
    localparam int CW   = $clog2(SLOTS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid,
    input  logic          flush,
    input  logic          out_valid,
    input  logic          out_ready,
    output logic          in_ready,
    output logic          accept,
    output logic          emit,
    output logic [CW-1:0] fill_cnt
);
    pack_state_t state;
    logic        out_free;
    logic        last;
    logic        has_data;
    logic        flush_req;

    // in_ready depends combinationally on out_ready; consumers must not loop it back.
    always_comb begin
        out_free  = !out_valid || out_ready;
        last      = fill_cnt == CW'(SLOTS - 1);
        in_ready  = state != FLUSH_WAIT && !(last && !out_free);
        accept    = in_valid && in_ready;
        has_data  = fill_cnt != '0 || accept;
        flush_req = flush || state == FLUSH_WAIT;
        emit      = (accept && last) || (flush_req && out_free && has_data);
    end

    // A flush with data that does not emit can only mean the output is busy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= EMPTY;
            fill_cnt <= '0;
        end else begin
            fill_cnt <= emit ? '0 : accept ? fill_cnt + CW'(1) : fill_cnt;
            state    <= emit ? EMPTY :
                        ((flush && has_data) || state == FLUSH_WAIT) ? FLUSH_WAIT :
                        has_data ? FILLING : EMPTY;
        end
    end
endmodule

// File: rtl/result_pack_buffer.sv
// result_pack_buffer: packs DATA_W results into OUT_W words with occupancy mask.
// Ports: clk_i, rst_i (async active-high), bus (result_pack_buffer_if.slave).
// Build option: RESULT_BUF_MSB_FIRST_EN fills slots from the top slot downwards.
module result_pack_buffer
    import calculator_pkg::*;
#(
    parameter int DATA_W = calculator_pkg::DATA_W,
    parameter int OUT_W  = calculator_pkg::MEM_WORD_SIZE,
    localparam int SLOTS = OUT_W / DATA_W,
    localparam int CW    = $clog2(SLOTS)
) (
    input logic                clk_i,
    input logic                rst_i,
    result_pack_buffer_if.slave bus
);
    if (OUT_W % DATA_W != 0 || SLOTS < 2) begin : g_bad_cfg
        $error("result_pack_buffer: OUT_W must be a multiple of DATA_W with at least 2 slots");
    end

`ifdef RESULT_BUF_MSB_FIRST_EN
    localparam bit MSB_FIRST = 1'b1;
`else
    localparam bit MSB_FIRST = 1'b0;
`endif

    logic             accept;
    logic             emit;
    logic [CW-1:0]    ptr;
    logic [CW:0]      n;
    logic [OUT_W-1:0] pack;
    logic [OUT_W-1:0] word;
    logic [SLOTS-1:0] mask_n;

    result_pack_ctrl #(.SLOTS(SLOTS)) u_ctrl (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_valid  (bus.in_valid),
        .flush     (bus.flush),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .in_ready  (bus.in_ready),
        .accept    (accept),
        .emit      (emit),
        .fill_cnt  (bus.fill_cnt)
    );

    // word is the pack register including this cycle's accepted result; unused
    // slots are already zero because pack clears on every emit.
    always_comb begin
        ptr  = MSB_FIRST ? CW'(SLOTS - 1) - bus.fill_cnt : bus.fill_cnt;
        word = pack;
        if (accept)
            word[int'(ptr)*DATA_W +: DATA_W] = bus.result;
        n = {1'b0, bus.fill_cnt} + (CW+1)'(accept);
        for (int i = 0; i < SLOTS; i++)
            mask_n[i] = MSB_FIRST ? (i >= SLOTS - int'(n)) : (i < int'(n));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pack          <= '0;
            bus.buffer    <= '0;
            bus.slot_mask <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            pack <= emit ? '0 : word;
            if (emit) begin
                bus.buffer    <= word;
                bus.slot_mask <= mask_n;
                bus.out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_result_pack_buffer.sv
// tb_result_pack_buffer: directed checks of packing, flush, backpressure and reset.
module tb_result_pack_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    result_pack_buffer_if #(.DATA_W(32), .OUT_W(64)) bus();

    result_pack_buffer dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Expected packed word for first-accepted a and second-accepted b.
    function automatic logic [63:0] pair(input logic [31:0] a, input logic [31:0] b);
`ifdef RESULT_BUF_MSB_FIRST_EN
        return {a, b};
`else
        return {b, a};
`endif
    endfunction

`ifdef RESULT_BUF_MSB_FIRST_EN
    localparam logic [1:0] MASK1 = 2'b10;
`else
    localparam logic [1:0] MASK1 = 2'b01;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.result = '0; bus.in_valid = 0; bus.flush = 0; bus.out_ready = 1;
        rst = 1;
        tick(); tick();
        #2 rst = 0;
        tick();
        total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", bus.out_valid); else passed++;
        total++; if (bus.buffer !== 64'h0) $display("FAIL reset_buffer: got %h want 0", bus.buffer); else passed++;
        total++; if (bus.slot_mask !== 2'b00) $display("FAIL reset_mask: got %b want 00", bus.slot_mask); else passed++;
        total++; if (bus.fill_cnt !== 1'b0) $display("FAIL reset_fill: got %0d want 0", bus.fill_cnt); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); else passed++;
    endtask

    task automatic test_pack();
        bus.out_ready = 1; bus.in_valid = 1; bus.result = 32'h1111_1111;
        tick();
        total++; if (bus.fill_cnt !== 1'b1) $display("FAIL pack_fill1: got %0d want 1", bus.fill_cnt); else passed++;
        bus.result = 32'h2222_2222;
        tick();
        bus.in_valid = 0;
        total++; if (bus.out_valid !== 1'b1) $display("FAIL pack_valid: got %0b want 1", bus.out_valid); else passed++;
        total++; if (bus.buffer !== pair(32'h1111_1111, 32'h2222_2222)) $display("FAIL pack_buffer: got %h want %h", bus.buffer, pair(32'h1111_1111, 32'h2222_2222)); else passed++;
        total++; if (bus.slot_mask !== 2'b11) $display("FAIL pack_mask: got %b want 11", bus.slot_mask); else passed++;
        total++; if (bus.fill_cnt !== 1'b0) $display("FAIL pack_fill0: got %0d want 0", bus.fill_cnt); else passed++;
        tick();
        total++; if (bus.out_valid !== 1'b0) $display("FAIL pack_drain: got %0b want 0", bus.out_valid); else passed++;
    endtask

    task automatic test_flush();
        bus.out_ready = 1; bus.in_valid = 1; bus.result = 32'hDEAD_BEEF;
        tick();
        bus.in_valid = 0; bus.flush = 1;
        tick();
        bus.flush = 0;
        total++; if (bus.out_valid !== 1'b1) $display("FAIL flush_valid: got %0b want 1", bus.out_valid); else passed++;
        total++; if (bus.buffer !== pair(32'hDEAD_BEEF, 32'h0)) $display("FAIL flush_buffer: got %h want %h", bus.buffer, pair(32'hDEAD_BEEF, 32'h0)); else passed++;
        total++; if (bus.slot_mask !== MASK1) $display("FAIL flush_mask: got %b want %b", bus.slot_mask, MASK1); else passed++;
        total++; if (bus.fill_cnt !== 1'b0) $display("FAIL flush_fill: got %0d want 0", bus.fill_cnt); else passed++;
        tick();
        bus.flush = 1;
        tick();
        bus.flush = 0;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL flush_empty_noop: got %0b want 0", bus.out_valid); else passed++;
        tick();
        total++; if (bus.out_valid !== 1'b0) $display("FAIL flush_empty_late: got %0b want 0", bus.out_valid); else passed++;
    endtask

    task automatic test_flush_full();
        bus.out_ready = 1; bus.in_valid = 1; bus.result = 32'h7;
        tick();
        bus.result = 32'h8; bus.flush = 1;
        tick();
        bus.in_valid = 0; bus.flush = 0;
        total++; if (bus.buffer !== pair(32'h7, 32'h8)) $display("FAIL flush_full_buffer: got %h want %h", bus.buffer, pair(32'h7, 32'h8)); else passed++;
        total++; if (bus.slot_mask !== 2'b11) $display("FAIL flush_full_mask: got %b want 11", bus.slot_mask); else passed++;
        tick();
        total++; if (bus.out_valid !== 1'b0) $display("FAIL flush_full_single: got %0b want 0", bus.out_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 0; bus.in_valid = 1; bus.result = 32'h1;
        tick();
        bus.result = 32'h2;
        tick();
        total++; if (bus.buffer !== pair(32'h1, 32'h2)) $display("FAIL bp_word1: got %h want %h", bus.buffer, pair(32'h1, 32'h2)); else passed++;
        bus.result = 32'h3;
        tick();
        bus.result = 32'h4;
        #1;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready_low: got %0b want 0", bus.in_ready); else passed++;
        total++; if (bus.fill_cnt !== 1'b1) $display("FAIL bp_fill: got %0d want 1", bus.fill_cnt); else passed++;
        tick();
        total++; if (bus.buffer !== pair(32'h1, 32'h2)) $display("FAIL bp_hold: got %h want %h", bus.buffer, pair(32'h1, 32'h2)); else passed++;
        total++; if (bus.fill_cnt !== 1'b1) $display("FAIL bp_fill_hold: got %0d want 1", bus.fill_cnt); else passed++;
        bus.out_ready = 1;
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_in_ready_high: got %0b want 1", bus.in_ready); else passed++;
        tick();
        bus.in_valid = 0;
        total++; if (bus.out_valid !== 1'b1) $display("FAIL bp_word2_valid: got %0b want 1", bus.out_valid); else passed++;
        total++; if (bus.buffer !== pair(32'h3, 32'h4)) $display("FAIL bp_word2: got %h want %h", bus.buffer, pair(32'h3, 32'h4)); else passed++;
        tick();
        total++; if (bus.out_valid !== 1'b0) $display("FAIL bp_drain: got %0b want 0", bus.out_valid); else passed++;
    endtask

    task automatic test_flush_wait();
        bus.out_ready = 0; bus.in_valid = 1; bus.result = 32'h10;
        tick();
        bus.result = 32'h20;
        tick();
        bus.result = 32'h30;
        tick();
        bus.in_valid = 0; bus.flush = 1;
        tick();
        bus.flush = 0;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL fw_in_ready: got %0b want 0", bus.in_ready); else passed++;
        total++; if (bus.buffer !== pair(32'h10, 32'h20)) $display("FAIL fw_hold: got %h want %h", bus.buffer, pair(32'h10, 32'h20)); else passed++;
        tick();
        total++; if (bus.in_ready !== 1'b0) $display("FAIL fw_in_ready_stay: got %0b want 0", bus.in_ready); else passed++;
        bus.out_ready = 1;
        tick();
        total++; if (bus.out_valid !== 1'b1) $display("FAIL fw_valid: got %0b want 1", bus.out_valid); else passed++;
        total++; if (bus.buffer !== pair(32'h30, 32'h0)) $display("FAIL fw_buffer: got %h want %h", bus.buffer, pair(32'h30, 32'h0)); else passed++;
        total++; if (bus.slot_mask !== MASK1) $display("FAIL fw_mask: got %b want %b", bus.slot_mask, MASK1); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL fw_in_ready_back: got %0b want 1", bus.in_ready); else passed++;
        total++; if (bus.fill_cnt !== 1'b0) $display("FAIL fw_fill: got %0d want 0", bus.fill_cnt); else passed++;
        tick();
        total++; if (bus.out_valid !== 1'b0) $display("FAIL fw_drain: got %0b want 0", bus.out_valid); else passed++;
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 0; bus.in_valid = 1; bus.result = 32'hA;
        tick();
        bus.result = 32'hB;
        tick();
        bus.result = 32'hAAAA_0001;
        tick();
        bus.in_valid = 0;
        #3 rst = 1;
        #1;
        total++; if (bus.buffer !== 64'h0) $display("FAIL rstmid_buffer: got %h want 0", bus.buffer); else passed++;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_valid: got %0b want 0", bus.out_valid); else passed++;
        total++; if (bus.fill_cnt !== 1'b0) $display("FAIL rstmid_fill: got %0d want 0", bus.fill_cnt); else passed++;
        #2 rst = 0;
        bus.out_ready = 1;
        tick();
        bus.in_valid = 1; bus.result = 32'h5;
        tick();
        bus.result = 32'h6;
        tick();
        bus.in_valid = 0;
        total++; if (bus.buffer !== pair(32'h5, 32'h6)) $display("FAIL rstmid_after: got %h want %h", bus.buffer, pair(32'h5, 32'h6)); else passed++;
        total++; if (bus.slot_mask !== 2'b11) $display("FAIL rstmid_mask: got %b want 11", bus.slot_mask); else passed++;
    endtask

    initial begin
        test_reset();
        test_pack();
        test_flush();
        test_flush_full();
        test_back_to_back();
        test_flush_wait();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/result_pack_buffer.md
Name: result_pack_buffer

Overview:
Packs a stream of DATA_W ALU results into OUT_W-bit memory words, SLOTS = OUT_W/DATA_W results per word. Slot selection is automatic through an internal fill pointer, so no external location select is needed. Completed or flushed words are presented on a valid/ready output with a per-slot occupancy mask. The block sits between the ALU result path and the memory write port; a pack register and an output holding register let packing overlap with output backpressure.

Parameters:
DATA_W, calculator_pkg::DATA_W (32), width of one result/slot
OUT_W, calculator_pkg::MEM_WORD_SIZE (64), packed word width; OUT_W % DATA_W == 0 and OUT_W/DATA_W >= 2, checked at elaboration
SLOTS, OUT_W/DATA_W (localparam, derived), number of slots per word

Ports:
clk_i  in  1  clock; all state updates on posedge
rst_i  in  1  reset, asynchronous and active-high
result_i  in  DATA_W  result from ALU
in_valid_i  in  1  result_i valid
in_ready_o  out  1  block can accept result_i this cycle
flush_i  in  1  single-cycle request to emit the partial word
buffer_o  out  OUT_W  packed word (output holding register)
slot_mask_o  out  SLOTS  bit i = physical slot i holds a valid result
out_valid_o  out  1  buffer_o/slot_mask_o valid
out_ready_i  in  1  consumer takes the word when out_valid_o && out_ready_i
fill_cnt_o  out  $clog2(SLOTS)  slots currently held in the pack register (0..SLOTS-1)

Behaviour:
- Reset (async, any cycle, including mid-word or mid-flush): pack register, buffer_o, slot_mask_o, fill count and flush-pending flag go to 0; out_valid_o = 0. in_ready_o = 1 from the first edge after release.
- Accept: in_valid_i && in_ready_o. result_i is written to the slot at the fill pointer and the fill count increments. Default fill order: slot 0 = bits [DATA_W-1:0], ascending.
- Output register free: out_valid_o == 0 || out_ready_i (same-cycle drain counts as free).
- Word completion: an accept at fill == SLOTS-1 moves the full word to the output register on the same edge. The next cycle shows out_valid_o = 1, slot_mask_o = all ones, and fill count 0. Latency is 1 cycle from the last accept.
- in_ready_o = !flush_pending && !(fill == SLOTS-1 && !out_free). This is combinational on out_ready_i and must not be used as a register input path back to out_ready_i.
- Hold: while out_valid_o && !out_ready_i, buffer_o and slot_mask_o are stable.
- Flush, accepted when out_free:
  - The pack register, plus any result accepted in the same cycle, moves to the output.
  - Unused slots are zero and their mask bits are clear. Fill count returns to 0.
- Flush when fill == 0 and there is no accept in the same cycle: no-op. An empty word is never emitted.
- Flush when the output is not free: flush_pending is set, in_ready_o drops, and the transfer happens on the first cycle the output is free. A new flush_i while pending is absorbed.
- Accept + flush in the same cycle at fill == SLOTS-1: a single full word is emitted, mask all ones.
- FSM states and transitions:
  - EMPTY (fill 0) -> FILLING on accept.
  - FILLING -> EMPTY on completion or flush transfer.
  - FILLING -> FLUSH_WAIT on flush with output busy.
  - FLUSH_WAIT -> EMPTY when out_free.

Optional Feature:
RESULT_BUF_MSB_FIRST_EN
- Defined: fill order descends. The first result goes to the top slot (bits [OUT_W-1:OUT_W-DATA_W]). slot_mask_o still indexes physical slots, so a single flushed result gives mask bit SLOTS-1.
- Undefined: LSB-first order as above.

Decomposition:
- calculator_pkg additions:
  - RESULT_SLOTS = MEM_WORD_SIZE/DATA_W
  - typedef slot_mask_t (logic [RESULT_SLOTS-1:0])
  - typedef enum pack_state_t {EMPTY, FILLING, FLUSH_WAIT}
- One sub-module, result_pack_ctrl: fill counter, FSM, flush-pending flag and in_ready_o logic. The datapath registers stay in result_pack_buffer.

Test Plan:
Defaults DATA_W=32, OUT_W=64.
1. Accept 0x1111_1111 then 0x2222_2222 back-to-back, out_ready_i=1 -> next cycle out_valid_o=1, buffer_o=0x2222_2222_1111_1111, slot_mask_o=2'b11, fill_cnt_o=0.
2. Accept 0xDEAD_BEEF, then pulse flush_i -> buffer_o=0x0000_0000_DEAD_BEEF, mask 2'b01. A second flush_i with fill 0 -> no new out_valid_o.
3. out_ready_i=0, offer results 1..4 continuously -> word {2,1} held stable, 3 accepted, in_ready_o=0 with fill 1. Raise out_ready_i -> {2,1} drained and then {4,3} emitted, order preserved.
4. Output held (out_ready_i=0), fill 1, flush_i pulse -> in_ready_o=0 (FLUSH_WAIT). On out_ready_i=1, partial word {0,x} with mask 2'b01 follows the held word.
5. Accept 0xAAAA_0001, assert rst_i between clock edges -> buffer_o=0, out_valid_o=0, fill_cnt_o=0 immediately. After release, 0x5 then 0x6 yields 0x0000_0006_0000_0005.
6. RESULT_BUF_MSB_FIRST_EN defined, scenario 1 -> buffer_o=0x1111_1111_2222_2222. Single result + flush -> mask 2'b10.
